riscv_fetch_ctrl: RTL and testbench
===================================

Name: riscv_fetch_ctrl

Overview:
Multi-cycle instruction fetch sequencer for the core. It owns the PC, issues one request at a time to instruction memory, and captures the returned word into an instruction register. It presents that word with a valid/ready handshake to the downstream riscv_decoder, and applies control-flow redirects from execute. At most one memory request is outstanding at any time, and only one instruction is buffered.

Parameters:
Bitness, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, PC loaded at reset (must be 4-byte aligned)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  Bitness  fetch byte address (always [1:0]=0)
imem_rsp_valid  input  1  read data valid (exactly one response per accepted request, no backpressure)
imem_rsp_data  input  Bitness  read data
instr_valid  output  1  instruction register holds a live instruction
instr_ready  input  1  decoder/issue consumes instruction
instruction  output  Bitness  instruction word to riscv_decoder
instr_pc  output  Bitness  PC of instruction
redirect_valid  input  1  branch/jump taken, single-cycle pulse
redirect_pc  input  Bitness  redirect target
misalign_o  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=REQ, pc=RESET_PC, drop=0.
  - imem_req_valid=0 while rst_n low.
  - imem_req_addr=RESET_PC.
  - instr_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=RESET_PC, misalign_o=0.
- First request: imem_req_valid rises in the first cycle after rst_n deasserts.
- FSM states: REQ, WAIT, HOLD. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready: go to WAIT.
  - Address is not sticky: it may change while valid is high and the request is not yet accepted (this only happens on redirect).
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=0: instruction<=imem_rsp_data, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - On imem_rsp_valid with drop=1: discard the data, drop<=0, go to REQ.
  - Responses in REQ or HOLD are protocol errors (assertion) and are ignored.
- HOLD:
  - instr_valid=1; instruction and instr_pc are stable until the handshake.
  - On instr_valid && instr_ready: instr_valid<=0, pc<=pc+4, go to REQ.
- Latency (no stalls, 1-cycle memory):
  - Request to instruction valid: 2 cycles.
  - Sustained throughput: one instruction per 3 cycles.
- PC arithmetic: modulo 2^Bitness. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Redirect, accepted in every state:
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - misalign_o=1 for the next cycle if redirect_pc[1:0]!=0.
- Redirect in REQ without ready: stay in REQ; new address is driven from the next cycle.
- Redirect in REQ with ready in the same cycle: the old-address request is in flight. Set drop<=1 and go to WAIT.
- Redirect in WAIT, no response: drop<=1; stay in WAIT.
- Redirect in WAIT with response in the same cycle: discard the response, drop stays 0, go to REQ.
- Redirect in HOLD: instr_valid<=0, go to REQ with the new pc. This applies whether or not instr_ready is high that cycle; a same-cycle handshake counts as consumed, and the redirect target overrides pc+4.
- Back-to-back redirects: the last one wins. drop is a single bit, which is sufficient because at most one request is outstanding.
- Reset mid-operation:
  - All state clears immediately and asynchronously; instr_valid drops at once.
  - Instruction memory must be reset in the same domain. A response arriving in REQ after reset is ignored.

Decomposition:
- Shared package riscv_pkg:
  - fetch_state_t enum {REQ, WAIT, HOLD}.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h0000_0013.
  - default RESET_PC.
- No sub-module: PC register, FSM and instruction register are a single block.
- riscv_decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, imem always ready, 1-cycle response, instr_ready=1 -> addresses 0x0, 0x4, 0x8 issued; instr_valid pulses with instr_pc 0x0/0x4/0x8 carrying the memory data.
- instr_ready held low 5 cycles in HOLD -> instruction/instr_pc stable, imem_req_valid=0, no new request until ready; then pc advances to +4.
- Redirect to 0x100 in WAIT, response arrives 3 cycles later -> response discarded, instr_valid stays 0, next request addr=0x100.
- Redirect to 0x200 in the same cycle as imem_rsp_valid -> data discarded, next addr=0x200, drop=0 (next response accepted).
- Redirect to 0x302 in HOLD with instr_ready=1 -> misalign_o pulses once, next addr=0x300, instr_valid low next cycle.
- pc=32'hFFFF_FFFC fetched and consumed -> next addr=0x0; assert rst_n low during WAIT -> instr_valid=0 and addr=RESET_PC immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types and constants for the RISC-V front end.
package riscv_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/riscv_fetch_ctrl.sv
// Multi-cycle fetch sequencer: owns the PC, issues one imem request at a time,
// buffers a single instruction for the decoder and applies execute redirects.
module riscv_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int                 Bitness  = 32,
    parameter logic [Bitness-1:0] RESET_PC = Bitness'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [Bitness-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [Bitness-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [Bitness-1:0] instruction,
    output logic [Bitness-1:0] instr_pc,
    input  logic               redirect_valid,
    input  logic [Bitness-1:0] redirect_pc,
    output logic               misalign_o
);

    fetch_state_t       r_state;
    logic [Bitness-1:0] r_pc;
    logic               r_drop;
    logic               r_req_valid;
    logic               r_instr_valid;
    logic [Bitness-1:0] r_instruction;
    logic [Bitness-1:0] r_instr_pc;
    logic               r_misalign;

    fetch_state_t       w_state_nxt;
    logic [Bitness-1:0] w_pc_seq;
    logic [Bitness-1:0] w_pc_nxt;
    logic [Bitness-1:0] w_redirect_aligned;
    logic               w_drop_nxt;
    logic               w_capture;
    logic               w_instr_valid_nxt;

    assign w_redirect_aligned = {redirect_pc[Bitness-1:2], 2'b00};
    assign w_pc_nxt           = redirect_valid ? w_redirect_aligned : w_pc_seq;

    // Next-state, next-PC and drop-flag decode; a redirect always overrides the sequential PC.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_seq          = r_pc;
        w_drop_nxt        = r_drop;
        w_capture         = 1'b0;
        w_instr_valid_nxt = r_instr_valid;
        case (r_state)
            REQ: begin
                // Acceptance needs the registered valid so nothing is accepted in the cycle out of reset.
                if (r_req_valid && imem_req_ready) begin
                    w_state_nxt = WAIT;
                    w_drop_nxt  = redirect_valid;
                end else begin
                    w_state_nxt = REQ;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_drop_nxt = 1'b0;
                    if (!redirect_valid && !r_drop) begin
                        w_capture         = 1'b1;
                        w_instr_valid_nxt = 1'b1;
                        w_state_nxt       = HOLD;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_drop_nxt = r_drop;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = REQ;
                    w_pc_seq          = r_pc + Bitness'(INSTR_BYTES);
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt       = REQ;
                w_drop_nxt        = 1'b0;
                w_instr_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and output registers; request valid is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= REQ;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instruction <= Bitness'(NOP_INSTR);
            r_instr_pc    <= RESET_PC;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drop        <= w_drop_nxt;
            r_req_valid   <= (w_state_nxt == REQ);
            r_instr_valid <= w_instr_valid_nxt;
            r_misalign    <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (w_capture) begin
                r_instruction <= imem_rsp_data;
                r_instr_pc    <= r_pc;
            end else begin
                r_instruction <= r_instruction;
                r_instr_pc    <= r_instr_pc;
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instruction    = r_instruction;
    assign instr_pc       = r_instr_pc;
    assign misalign_o     = r_misalign;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed cycle-table bench for riscv_fetch_ctrl with a small imem responder.
module tb_riscv_fetch_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_o;

    int          total = 0;
    int          bad   = 0;
    int          rsp_dly = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    riscv_fetch_ctrl #(.Bitness(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // imem responder: a request seen valid&ready at a falling edge is accepted on the next
    // rising edge; the response is driven rsp_dly falling edges later for one cycle.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pend_cnt       = 0;
            imem_rsp_valid = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_cnt  = rsp_dly;
                pend_addr = imem_req_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        irdy;
        int          dly;
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic        mis;
    } vec_t;

    vec_t vt[36];

    function automatic vec_t mk(input logic rdy, input logic irdy, input int dly,
                                input logic redir, input logic [31:0] rpc,
                                input logic rv, input logic [31:0] addr,
                                input logic iv, input logic [31:0] ipc, input logic mis);
        vec_t v;
        v.rdy = rdy; v.irdy = irdy; v.dly = dly; v.redir = redir; v.rpc = rpc;
        v.rv = rv; v.addr = addr; v.iv = iv; v.ipc = ipc; v.mis = mis;
        return v;
    endfunction

    initial begin
        logic found;
        // Row = inputs applied at this falling edge, outputs expected at this falling edge.
        vt[0]  = mk(1, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0);
        vt[1]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vt[2]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0);
        vt[3]  = mk(1, 1, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0,        0);
        vt[4]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h4,        0, 32'h0,        0);
        vt[5]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h4,        1, 32'h4,        0);
        vt[6]  = mk(1, 1, 1, 0, 32'h0,        1, 32'h8,        0, 32'h4,        0);
        vt[7]  = mk(1, 1, 1, 0, 32'h0,        0, 32'h8,        0, 32'h4,        0);
        vt[8]  = mk(1, 0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h8,        0);
        vt[9]  = mk(1, 0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h8,        0);
        vt[10] = mk(1, 0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h8,        0);
        vt[11] = mk(1, 0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h8,        0);
        vt[12] = mk(1, 0, 1, 0, 32'h0,        0, 32'h8,        1, 32'h8,        0);
        vt[13] = mk(1, 1, 1, 0, 32'h0,        0, 32'h8,        1, 32'h8,        0);
        vt[14] = mk(1, 1, 3, 0, 32'h0,        1, 32'hC,        0, 32'h8,        0);
        vt[15] = mk(1, 1, 3, 1, 32'h100,      0, 32'hC,        0, 32'h8,        0);
        vt[16] = mk(1, 1, 3, 0, 32'h0,        0, 32'h100,      0, 32'h8,        0);
        vt[17] = mk(1, 1, 1, 0, 32'h0,        0, 32'h100,      0, 32'h8,        0);
        vt[18] = mk(1, 1, 1, 0, 32'h0,        1, 32'h100,      0, 32'h8,        0);
        vt[19] = mk(1, 1, 1, 1, 32'h200,      0, 32'h100,      0, 32'h8,        0);
        vt[20] = mk(1, 1, 1, 0, 32'h0,        1, 32'h200,      0, 32'h8,        0);
        vt[21] = mk(1, 1, 1, 0, 32'h0,        0, 32'h200,      0, 32'h8,        0);
        vt[22] = mk(1, 1, 1, 1, 32'h302,      0, 32'h200,      1, 32'h200,      0);
        vt[23] = mk(1, 1, 1, 0, 32'h0,        1, 32'h300,      0, 32'h200,      1);
        vt[24] = mk(1, 1, 1, 0, 32'h0,        0, 32'h300,      0, 32'h200,      0);
        vt[25] = mk(1, 1, 1, 0, 32'h0,        0, 32'h300,      1, 32'h300,      0);
        vt[26] = mk(1, 1, 1, 1, 32'h400,      1, 32'h304,      0, 32'h300,      0);
        vt[27] = mk(1, 1, 1, 0, 32'h0,        0, 32'h400,      0, 32'h300,      0);
        vt[28] = mk(1, 1, 1, 0, 32'h0,        1, 32'h400,      0, 32'h300,      0);
        vt[29] = mk(1, 1, 1, 0, 32'h0,        0, 32'h400,      0, 32'h300,      0);
        vt[30] = mk(1, 1, 1, 0, 32'h0,        0, 32'h400,      1, 32'h400,      0);
        vt[31] = mk(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h404,      0, 32'h400,      0);
        vt[32] = mk(1, 1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h400,      0);
        vt[33] = mk(1, 1, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h400,      0);
        vt[34] = mk(1, 1, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
        vt[35] = mk(1, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'hFFFF_FFFC, 0);

        rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0; rsp_dly = 1;
        repeat (3) @(negedge clk);
        chk("rst_req_valid",   {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr",    imem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instruction", instruction, NOP_INSTR);
        chk("rst_instr_pc",    instr_pc, 32'h0);
        chk("rst_misalign",    {31'h0, misalign_o}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            chk($sformatf("c%0d_req_valid", i + 1), {31'h0, imem_req_valid}, {31'h0, vt[i].rv});
            chk($sformatf("c%0d_req_addr", i + 1), imem_req_addr, vt[i].addr);
            chk($sformatf("c%0d_instr_valid", i + 1), {31'h0, instr_valid}, {31'h0, vt[i].iv});
            chk($sformatf("c%0d_instr_pc", i + 1), instr_pc, vt[i].ipc);
            chk($sformatf("c%0d_misalign", i + 1), {31'h0, misalign_o}, {31'h0, vt[i].mis});
            if (vt[i].iv) begin
                chk($sformatf("c%0d_instruction", i + 1), instruction, mem_word(vt[i].ipc));
            end
            imem_req_ready = vt[i].rdy;
            instr_ready    = vt[i].irdy;
            rsp_dly        = vt[i].dly;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
        end

        // Asynchronous reset while a request is outstanding.
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h4) found = 1'b1;
        end
        chk("reach_req_4", {31'h0, found}, 32'h1);
        rsp_dly = 3;
        @(negedge clk);
        chk("wait_req_valid", {31'h0, imem_req_valid}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid",   {31'h0, imem_req_valid}, 32'h0);
        chk("arst_req_addr",    imem_req_addr, 32'h0);
        chk("arst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_instruction", instruction, NOP_INSTR);
        @(negedge clk);
        rst_n = 1'b1; rsp_dly = 1;
        @(negedge clk);
        chk("rel_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("rel_req_addr",  imem_req_addr, 32'h0);

        // Asynchronous reset while an instruction is held.
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (instr_valid) found = 1'b1;
        end
        chk("reach_hold", {31'h0, found}, 32'h1);
        chk("hold_instr_pc", instr_pc, 32'h0);
        chk("hold_instruction", instruction, mem_word(32'h0));
        rst_n = 1'b0;
        #1;
        chk("hrst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("hrst_instruction", instruction, NOP_INSTR);
        chk("hrst_instr_pc",    instr_pc, 32'h0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
